// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and register-bus signals between the UART command sequencer and its neighbours.
// The controller uses the master modport; the UART/register side uses slave.
interface uart_cmd_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        reg_rvld;

    modport master (
        input  rx_data, rx_vld, tx_rdy, reg_rdata, reg_rvld,
        output tx_data, tx_vld, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport slave (
        output rx_data, rx_vld, tx_rdy, reg_rdata, reg_rvld,
        input  tx_data, tx_vld, reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Collects 4-byte UART command frames and turns each into one register write or read;
// read data goes back out as two bytes (low first). Bad opcodes and timeouts are counted.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  OP_WR       = 8'h01,
    parameter logic [7:0]  OP_RD       = 8'h02
) (
    input  logic                   clk_sys,
    input  logic                   rst,
    uart_cmd_ctrl_if.master        bus,
    output logic                   busy,
    output logic                   err_pulse,
    output logic [7:0]             err_cnt
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_GET1, S_GET2, S_GET3, S_EXEC, S_WAIT_RD, S_TX_LO, S_TX_HI
    } state_t;

    state_t             state, state_d;
    logic               is_rd, is_rd_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [7:0]         rdata_hi, rdata_hi_d;
    logic [7:0]         tx_data_d;
    logic [7:0]         addr_d;
    logic [15:0]        wdata_d;
    logic               err_c;
    logic               timeout_c;
    logic               tx_xfer_c;

    // Counter value one cycle before it would reach TIMEOUT_CYC-1.
    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYC - 32'd2));
    assign tx_xfer_c = bus.tx_vld & bus.tx_rdy;

    // Next-state and next-register values.
    always_comb begin
        state_d    = state;
        is_rd_d    = is_rd;
        cnt_d      = cnt;
        rdata_hi_d = rdata_hi;
        tx_data_d  = bus.tx_data;
        addr_d     = bus.reg_addr;
        wdata_d    = bus.reg_wdata;
        err_c      = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.rx_vld) begin
                    if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
                        is_rd_d = (bus.rx_data == OP_RD);
                        cnt_d   = '0;
                        state_d = S_GET1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            S_GET1, S_GET2, S_GET3: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (bus.rx_vld) begin
                    cnt_d = '0;
                    if (state == S_GET1) begin
                        addr_d  = bus.rx_data;
                        state_d = S_GET2;
                    end else if (state == S_GET2) begin
                        if (!is_rd) wdata_d[7:0] = bus.rx_data;
                        state_d = S_GET3;
                    end else begin
                        if (!is_rd) wdata_d[15:8] = bus.rx_data;
                        state_d = S_EXEC;
                    end
                end else if (timeout_c) begin
                    err_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_EXEC: begin
                err_c   = bus.rx_vld;
                cnt_d   = '0;
                state_d = is_rd ? S_WAIT_RD : S_IDLE;
            end
            S_WAIT_RD: begin
                err_c = bus.rx_vld;
                if (bus.reg_rvld) begin
                    tx_data_d  = bus.reg_rdata[7:0];
                    rdata_hi_d = bus.reg_rdata[15:8];
                    state_d    = S_TX_LO;
                end else if (timeout_c) begin
                    err_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_TX_LO: begin
                err_c = bus.rx_vld;
                if (tx_xfer_c) begin
                    tx_data_d = rdata_hi;
                    state_d   = S_TX_HI;
                end
            end
            S_TX_HI: begin
                err_c = bus.rx_vld;
                if (tx_xfer_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the upcoming state.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state         <= S_IDLE;
            is_rd         <= 1'b0;
            cnt           <= '0;
            rdata_hi      <= '0;
            bus.tx_data   <= '0;
            bus.tx_vld    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_wr    <= 1'b0;
            bus.reg_rd    <= 1'b0;
            busy          <= 1'b0;
            err_pulse     <= 1'b0;
            err_cnt       <= '0;
        end else begin
            state         <= state_d;
            is_rd         <= is_rd_d;
            cnt           <= cnt_d;
            rdata_hi      <= rdata_hi_d;
            bus.tx_data   <= tx_data_d;
            bus.tx_vld    <= (state_d == S_TX_LO) || (state_d == S_TX_HI);
            bus.reg_addr  <= addr_d;
            bus.reg_wdata <= wdata_d;
            bus.reg_wr    <= (state_d == S_EXEC) && !is_rd_d;
            bus.reg_rd    <= (state_d == S_EXEC) && is_rd_d;
            busy          <= (state_d != S_IDLE);
            err_pulse     <= err_c;
            if (err_c && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
